uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small power-of-two FIFO.
// One start bit, eight data bits LSB first and one stop bit, each CLKS_PER_BIT clocks long.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [CW-1:0] baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;

  logic fifo_empty;
  logic baud_done;
  logic push;
  logic pop;

  assign fifo_empty = (count_reg == '0);
  assign baud_done  = (baud_reg == BAUD_LAST);
  // Readiness comes from the stored count only, so a full FIFO refuses a byte even on a pop edge.
  assign tx_ready   = (count_reg != FIFO_FULL);
  assign push       = tx_valid && tx_ready && !rst;
  assign pop        = !fifo_empty && ((state_reg == IDLE) || (state_reg == STOP && baud_done));
  assign tx         = tx_reg;
  assign busy       = (state_reg != IDLE) || !fifo_empty;

  // Storage has no reset so it can map onto distributed or block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      // The line follows the state one cycle later, giving the two-edge accept-to-start latency.
      case (state_reg)
        START:   tx_reg <= 1'b0;
        DATA:    tx_reg <= shift_reg[0];
        default: tx_reg <= 1'b1;
      endcase

      case (state_reg)
        IDLE: begin
          if (pop) begin
            shift_reg   <= mem[rd_ptr_reg];
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            state_reg   <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_reg  <= '0;
            state_reg <= DATA;
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_reg    <= '0;
            shift_reg   <= {1'b0, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (pop) begin
              shift_reg   <= mem[rd_ptr_reg];
              bit_idx_reg <= '0;
              state_reg   <= START;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: accepted bytes go into a scoreboard queue and
// a line monitor decodes every frame, checks bit timing and pops/compares the byte.
module tb_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         fstart[$];
  bit         mon_en = 1'b0;
  bit         mon_active = 1'b0;

  // Line monitor: samples on falling edges, one sample per clock, CPB samples per bit.
  initial begin
    logic [9:0] frame;
    logic       bitv;
    bit         shape_ok;
    logic [7:0] expb;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
        mon_active = 1'b1;
        fstart.push_back(cyc);
        frame = '0;
        bitv = 1'b0;
        shape_ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < CPB; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (k == 0) bitv = tx;
            else if (tx !== bitv) shape_ok = 1'b0;
          end
          frame[b] = bitv;
        end
        checks++;
        if (!shape_ok) begin
          errors++;
          $display("FAIL frame_shape: frame at cycle %0d bits=%b, required every bit held %0d cycles", fstart[$], frame, CPB);
        end
        checks++;
        if (frame[9] !== 1'b1) begin
          errors++;
          $display("FAIL stop_bit: frame at cycle %0d stop=%b, required 1", fstart[$], frame[9]);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: frame at cycle %0d data=%02h, required no frame", fstart[$], frame[8:1]);
        end else begin
          expb = sb.pop_front();
          if (frame[8:1] !== expb) begin
            errors++;
            $display("FAIL frame_data: frame at cycle %0d data=%02h, required %02h", fstart[$], frame[8:1], expb);
          end
        end
        $display("frame start=%0d data=%02h stop=%b", fstart[$], frame[8:1], frame[9]);
        mon_active = 1'b0;
      end
    end
  end

  // Must be called right after a falling edge; returns right after the falling edge following acceptance.
  task automatic send(input logic [7:0] d, input int bound, output int acc);
    tx_valid = 1'b1;
    tx_data  = d;
    acc = -1;
    for (int i = 0; i < bound; i++) begin
      if (tx_ready === 1'b1) begin
        acc = cyc + 1;
        sb.push_back(d);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL send_accept: byte %02h not accepted in %0d cycles, tx_ready=%b required 1", d, bound, tx_ready);
    end else begin
      $display("push data=%02h accepted at cycle %0d", d, acc);
    end
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0 || mon_active) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes pending busy=%b after %0d cycles, required 0 pending", sb.size(), busy, bound);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    mon_en   = 1'b1;
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: tx=%b required 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b required 0", busy); end
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: tx_ready=%b required 1", tx_ready); end
    rst      = 1'b0;
    tx_valid = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_push_dropped: busy=%b required 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_idle;
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
        errors++;
        bad++;
        if (bad < 4) $display("FAIL idle: tx=%b busy=%b tx_ready=%b, required 1 0 1", tx, busy, tx_ready);
      end
    end
    $display("test_idle done");
  endtask

  task automatic test_first_push;
    int rel;
    int acc;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    send(8'h5A, 10, acc);
    tx_valid = 1'b0;
    checks++;
    if (acc != rel + 1) begin errors++; $display("FAIL first_cycle_push: accepted at %0d, required %0d", acc, rel + 1); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: busy=%b required 1", busy); end
    wait_drain(200);
    $display("test_first_push done");
  endtask

  task automatic test_single;
    int acc;
    fstart.delete();
    send(8'hA5, 10, acc);
    tx_valid = 1'b0;
    while (cyc < acc + 40) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_stop: busy=%b required 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL busy_fall: busy=%b tx=%b required 0 1", busy, tx); end
    wait_drain(200);
    checks++;
    if (fstart.size() != 1) begin
      errors++;
      $display("FAIL single_frames: %0d frames, required 1", fstart.size());
    end else if (fstart[0] - acc != 2) begin
      errors++;
      $display("FAIL start_latency: %0d cycles, required 2", fstart[0] - acc);
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back;
    int acc[6];
    fstart.delete();
    for (int i = 0; i < 6; i++) begin
      send(8'(i + 1), 60, acc[i]);
      if (i == 4) begin
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready: tx_ready=%b required 0", tx_ready); end
      end
    end
    tx_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (acc[i] - acc[0] != i) begin errors++; $display("FAIL b2b_accept%0d: offset %0d, required %0d", i, acc[i] - acc[0], i); end
    end
    checks++;
    if (acc[5] - acc[0] != 42) begin errors++; $display("FAIL b2b_accept5: offset %0d, required 42", acc[5] - acc[0]); end
    wait_drain(600);
    checks++;
    if (fstart.size() != 6) begin
      errors++;
      $display("FAIL b2b_frames: %0d frames, required 6", fstart.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (fstart[i] - fstart[i-1] != 40) begin
          errors++;
          $display("FAIL b2b_gap%0d: %0d cycles, required 40", i, fstart[i] - fstart[i-1]);
        end
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_full_same_edge;
    int a0;
    int tmp;
    bit ok = 1'b1;
    fstart.delete();
    send(8'h11, 10, a0);
    for (int i = 0; i < 4; i++) send(8'(8'h12 + i), 10, tmp);
    tx_data = 8'h16;
    while (cyc <= a0 + 40) begin
      if (tx_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL full_hold: tx_ready=1 seen while full, required 0"); end
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL pop_edge_reject: tx_ready=%b required 1 (count 3)", tx_ready); end
    sb.push_back(8'h16);
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL retry_accept: tx_ready=%b required 0 (count 4)", tx_ready); end
    wait_drain(600);
    checks++;
    if (fstart.size() != 6 || fstart[$] - fstart[0] != 200) begin
      errors++;
      $display("FAIL full_frames: %0d frames, required 6 spanning 200 cycles", fstart.size());
    end
    $display("test_full_same_edge done");
  endtask

  task automatic test_zeros_ones;
    int tmp;
    fstart.delete();
    send(8'h00, 10, tmp);
    send(8'hFF, 10, tmp);
    tx_valid = 1'b0;
    wait_drain(300);
    checks++;
    if (fstart.size() != 2 || fstart[1] - fstart[0] != 40) begin
      errors++;
      $display("FAIL zeros_ones_gap: %0d frames, required 2 frames 40 cycles apart", fstart.size());
    end
    $display("test_zeros_ones done");
  endtask

  task automatic test_mid_frame_reset;
    int a;
    int tmp;
    bit ok = 1'b1;
    mon_en = 1'b0;
    send(8'h3C, 10, a);
    send(8'h55, 10, tmp);
    send(8'h66, 10, tmp);
    tx_valid = 1'b0;
    while (cyc < a + 18) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL data_bit3: tx=%b required 1", tx); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset: tx=%b busy=%b tx_ready=%b, required 1 0 1", tx, busy, tx_ready);
    end
    rst = 1'b0;
    sb.delete();
    repeat (80) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL post_reset_quiet: line or busy activity seen, required tx=1 busy=0"); end
    $display("test_mid_frame_reset done");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_first_push();
    test_single();
    test_back_to_back();
    test_full_same_edge();
    test_zeros_ones();
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
